// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, threshold flags,
// sticky overflow/underflow errors and an optional first-word-fall-through read port.
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       w_en,
    input  logic [DATA_W-1:0]          d_in,
    input  logic                       r_en,
    output logic [DATA_W-1:0]          d_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              wr_ok;
    logic              rd_ok;

    // Flags decode only the count register, so requests never reach them combinationally.
    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_THRESH));
    assign almost_empty = (count <= CW'(AE_THRESH));

    assign wr_ok = w_en && !full;
    assign rd_ok = r_en && !empty;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= d_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // A new error event wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (w_en && full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (r_en && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign d_out = mem[rd_ptr];
        end else begin : g_std
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    d_out <= '0;
                end else if (rd_ok) begin
                    d_out <= mem[rd_ptr];
                end
            end
        end
    endgenerate

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Single-clock, fully parametrised FIFO; successor to the fixed 16x8 dual-clock FIFO.
- Generalised in data width and depth.
- Adds programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags and a first-word-fall-through (FWFT) read mode.
- Used as the buffering primitive wherever producer and consumer share a clock.

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- DEPTH, 16, number of entries; power of two, >=4.
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH (1..DEPTH).
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1).
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- w_en  in  1  write request.
- d_in  in  DATA_W  write data.
- r_en  in  1  read request (FWFT: acknowledge/pop of the head word).
- d_out  out  DATA_W  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.
- clr_err  in  1  synchronous clear of overflow/underflow.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (rst_n low, asynchronous, no clock needed):
  - wr_ptr = rd_ptr = 0, count = 0, d_out = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - overflow = underflow = 0.
  - Memory contents are not reset.
- Reset asserted mid-operation: all stored data is discarded. The first cycle after release behaves as the first cycle after power-on reset.
- Write acceptance:
  - A write is accepted iff w_en && !full.
  - An accepted write stores d_in at mem[wr_ptr]; wr_ptr increments modulo DEPTH (natural wrap, no special case).
- Read acceptance:
  - A read is accepted iff r_en && !empty.
  - An accepted read increments rd_ptr modulo DEPTH.
- Count:
  - Count increments on a write-only cycle and decrements on a read-only cycle.
  - Count is unchanged when both are accepted in the same cycle.
  - Count never exceeds DEPTH and never goes below 0.
- Simultaneous w_en and r_en:
  - When full, only the read is accepted; the write is blocked and overflow sets.
  - When empty, only the write is accepted; the read is blocked and underflow sets.
  - Otherwise both are accepted.
- Flags:
  - All flags are decoded from the count register, so each is valid in the cycle after the causing edge. There is no combinational path from w_en/r_en to any flag.
- Standard mode (FWFT=0):
  - d_out is registered and loads mem[rd_ptr] on the edge of an accepted read. Read latency is 1 cycle.
  - d_out holds its value on idle or blocked reads.
- FWFT mode (FWFT=1):
  - d_out = mem[rd_ptr] continuously; it is valid whenever empty == 0, with no r_en needed.
  - An accepted r_en pops the head, and d_out shows the next word in the following cycle.
  - d_out is don't-care while empty.
  - The first written word appears on d_out in the cycle empty deasserts, one cycle after the write edge.
- Errors:
  - A blocked write sets overflow; a blocked read sets underflow.
  - Both flags are sticky until clr_err is high at a clock edge.
  - If clr_err and a new error event occur in the same cycle, the set takes priority.
  - Blocked operations never modify memory, pointers, count or d_out.

Test Plan:
- Reset, then check defaults:
  - Hold rst_n low, then release.
  - Required: count=0, empty=1, almost_empty=1, full=0, almost_full=0, d_out=0, overflow=0, underflow=0.
- Fill, overflow and drain (DEPTH=16, FWFT=0):
  - Write 0x00..0x0F on consecutive cycles.
  - Required: almost_full rises when count reaches 14; full=1 and count=16 after the 16th write.
  - Write 0xAA while full: overflow=1 and memory unchanged.
  - Drain 16 reads: d_out sequence is 0x00..0x0F, each 1 cycle after its read.
  - One extra read: underflow=1 and d_out holds 0x0F.
- Simultaneous read/write:
  - At count=5, assert w_en and r_en for 10 cycles. Required: count stays 5 and output order is preserved.
  - At full, assert w_en and r_en. Required: count goes to 15 and overflow=1.
  - At empty, assert w_en and r_en. Required: count goes to 1 and underflow=1.
- Wrap-around:
  - Perform 40 interleaved writes/reads of an incrementing pattern, passing both pointers past DEPTH twice.
  - Required: the read stream exactly matches the write stream and no errors are flagged.
- FWFT mode (FWFT=1):
  - Write 0x5A. Required: next cycle empty=0 and d_out=0x5A without r_en.
  - Write 0x5B, then pulse r_en. Required: d_out=0x5B the following cycle.
- Reset mid-operation and error clear:
  - At count=7 with overflow=1, assert rst_n low asynchronously between edges. Required: flags and count reset immediately.
  - Separately, pulse clr_err with no error event. Required: overflow and underflow clear.
  - Pulse clr_err together with a blocked write. Required: overflow stays 1.
